// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   The single shared memory port that carries both instruction fetches and
//   data loads/stores.
//   master : the arbiter. It drives the request, write enable, address and
//            write data, and receives the read data and the acknowledge.
//   slave  : the memory. It drives mem_rdata/mem_ack. mem_ack is only
//            meaningful while mem_req=1.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one unified memory port between instruction fetch (F) and
//   loads/stores (M). A data access always wins because the instruction in M
//   is older. The arbiter buffers one fetched instruction and produces the
//   extra stalls that the hazard unit ORs into its StallF/StallD/FlushE
//   network. A watchdog raises a sticky MemErr if the memory never
//   acknowledges.
//
// Ports
//   clk, rst         rising-edge clock, synchronous active-high reset
//   PCF_i            fetch address
//   FetchHold_i      fetch stage frozen this cycle
//   Redirect_i       taken branch/jump in E; the in-flight fetch is stale
//   DataReqM_i       load/store present in M
//   DataWeM_i        1 = store
//   ALUResultM_i     data address
//   WriteDataM_i     store data
//   InstrF_o         buffered instruction
//   InstrValidF_o    InstrF_o belongs to the current PCF
//   StallIF_o        no instruction available yet
//   ReadDataM_o      load data, valid while DataDoneM_o=1
//   DataDoneM_o      one-cycle pulse when the M access completes
//   StallMem_o       freeze F/D/E/M while a data access is in progress
//   MemErr_o         sticky watchdog flag
//   mem              memory port (master side)
//
// States
//   state  | meaning
//   IDLE   | port idle; picks data, then fetch, else nothing
//   I_WAIT | instruction read outstanding
//   D_WAIT | data access outstanding
//   D_DONE | data complete; pipeline advances this cycle
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] PCF_i,
    input  logic              FetchHold_i,
    input  logic              Redirect_i,
    input  logic              DataReqM_i,
    input  logic              DataWeM_i,
    input  logic [ADDR_W-1:0] ALUResultM_i,
    input  logic [DATA_W-1:0] WriteDataM_i,
    output logic [DATA_W-1:0] InstrF_o,
    output logic              InstrValidF_o,
    output logic              StallIF_o,
    output logic [DATA_W-1:0] ReadDataM_o,
    output logic              DataDoneM_o,
    output logic              StallMem_o,
    output logic              MemErr_o,
    mem_arbiter_if.master     mem
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_I_WAIT = 2'd1,
        S_D_WAIT = 2'd2,
        S_D_DONE = 2'd3
    } state_t;

    // Watchdog is a down-counter reloaded whenever no access is waiting;
    // reaching zero means TIMEOUT wait cycles went by without an ack.
    localparam logic [7:0] WD_LOAD = 8'(TIMEOUT);

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              ivalid_q, ivalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              drop_q, drop_d;
    logic [7:0]        wd_q, wd_d;
    logic              err_q, err_d;

    logic              ack;
    logic              done;
    logic              stall_mem;

    // The memory's ack means nothing unless a request is actually out.
    assign ack       = mem.mem_ack & req_q;
    assign done      = (state_q == S_D_DONE);
    assign stall_mem = DataReqM_i & ~done;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            instr_q  <= '0;
            ivalid_q <= 1'b0;
            rdata_q  <= '0;
            drop_q   <= 1'b0;
            wd_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            instr_q  <= instr_d;
            ivalid_q <= ivalid_d;
            rdata_q  <= rdata_d;
            drop_q   <= drop_d;
            wd_q     <= wd_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (DataReqM_i) begin
                    state_d = S_D_WAIT;
                end else if (!ivalid_q && !Redirect_i) begin
                    state_d = S_I_WAIT;
                end
            end
            S_I_WAIT: begin
                if (ack) begin
                    state_d = S_IDLE;
                end
            end
            S_D_WAIT: begin
                if (ack) begin
                    state_d = S_D_DONE;
                end
            end
            // Always fall back to IDLE so the M instruction that just
            // completed is never issued a second time.
            S_D_DONE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        instr_d  = instr_q;
        ivalid_d = ivalid_q;
        rdata_d  = rdata_q;
        drop_d   = drop_q;
        wd_d     = WD_LOAD;
        err_d    = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (DataReqM_i) begin
                    req_d   = 1'b1;
                    we_d    = DataWeM_i;
                    addr_d  = ALUResultM_i;
                    wdata_d = WriteDataM_i;
                end else if (!ivalid_q && !Redirect_i) begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = PCF_i;
                end
            end
            S_I_WAIT, S_D_WAIT: begin
                if (ack) begin
                    req_d  = 1'b0;
                    drop_d = 1'b0;
                    if (state_q == S_I_WAIT) begin
                        // A redirect now or earlier makes this word stale.
                        if (!drop_q && !Redirect_i) begin
                            instr_d = mem.mem_rdata;
                        end
                    end else if (!we_q) begin
                        // Stores leave the last load value in place.
                        rdata_d = mem.mem_rdata;
                    end
                end else begin
                    if (state_q == S_I_WAIT && Redirect_i) begin
                        drop_d = 1'b1;
                    end
                    // Keep waiting after the error; only the flag is raised.
                    wd_d = (wd_q != 8'd0) ? wd_q - 8'd1 : 8'd0;
                    if (wd_q == 8'd1) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // A fresh instruction landing this edge takes precedence over the
        // consume-clear, which only applies to a word already held.
        if (Redirect_i) begin
            ivalid_d = 1'b0;
        end else if (state_q == S_I_WAIT && ack && !drop_q) begin
            ivalid_d = 1'b1;
        end else if (!FetchHold_i && !stall_mem) begin
            ivalid_d = 1'b0;
        end
    end

    assign InstrF_o      = instr_q;
    assign InstrValidF_o = ivalid_q;
    assign StallIF_o     = ~ivalid_q;
    assign ReadDataM_o   = rdata_q;
    assign DataDoneM_o   = done;
    assign StallMem_o    = stall_mem;
    assign MemErr_o      = err_q;

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

endmodule
